// File: rtl/bus_arb8_if.sv
// Request/grant bundle between eight requesting units and the bus arbiter.
// Latency: none, plain wires.
// Backpressure: none; a requester simply holds req until it sees its gnt bit.
interface bus_arb8_if;
    logic [7:0] req;   // bit i: source i wants the shared mux
    logic       done;  // current owner ends its tenure this cycle
    logic [7:0] gnt;   // one-hot grant, zero when idle
    logic [2:0] sel;   // mux select: index of current/last owner
    logic       busy;  // a grant is active

    // Requester side: drives requests/done, observes grant state.
    modport master (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output sel,
        output busy
    );
endinterface

// File: rtl/bus_arb8.sv
// Round-robin arbiter for an 8-source shared datapath mux, with a tenure limit.
// Latency: request to grant one edge; hand-over happens on the releasing edge, no idle bubble.
// Backpressure: requesters hold req until granted; a tenure ends on done, req drop, or MAX_HOLD cycles.
module bus_arb8 #(
    parameter int unsigned MAX_HOLD = 16   // 0 = unlimited tenure, else 1..255
) (
    input  logic       clk,
    input  logic       rst,
    bus_arb8_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last value hold_q reaches before a forced release; unused when MAX_HOLD is 0.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] owner_q, owner_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] gnt_q, gnt_d;

    logic [2:0] search_base;
    logic [2:0] search_idx;
    logic [2:0] cand;
    logic       search_vld;
    logic       limit_hit;
    logic       release_w;

    // Release conditions for the current owner; other sources' req bits play no part.
    always_comb begin
        limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
        release_w = bus.done || !bus.req[owner_q] || limit_hit;
    end

    // Priority search from the base index upward with wrap; in GRANT the base is owner+1
    // so a hand-over can be resolved in the same cycle the release is seen.
    always_comb begin
        search_base = (state_q == GRANT) ? 3'(owner_q + 3'd1) : ptr_q;
        search_vld  = 1'b0;
        search_idx  = search_base;
        cand        = search_base;
        for (int k = 0; k < 8; k++) begin
            cand = 3'(search_base + 3'(k));
            if (!search_vld && bus.req[cand]) begin
                search_vld = 1'b1;
                search_idx = cand;
            end
        end
    end

    // Next-state logic: grant from idle, extend tenure, or release and hand over.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                // done is meaningless without an owner, so only req matters here.
                if (search_vld) begin
                    state_d = GRANT;
                    owner_d = search_idx;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                if (release_w) begin
                    ptr_d = 3'(owner_q + 3'd1);
                    if (search_vld) begin
                        owner_d = search_idx;
                        hold_d  = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = 8'(hold_q + 8'd1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        gnt_d = (state_d == GRANT) ? (8'b1 << owner_d) : 8'h00;
    end

    // State and output registers; reset clears grant asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            owner_q <= 3'd0;
            hold_q  <= 8'd0;
            gnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    // Outputs come straight from registers; sel keeps the last owner while idle.
    always_comb begin
        bus.gnt  = gnt_q;
        bus.sel  = owner_q;
        bus.busy = (state_q == GRANT);
    end

endmodule

// File: tb/tb_bus_arb8.sv
// Self-checking bench for bus_arb8 with MAX_HOLD=4: directed scenarios plus a random tail.
// Latency: outputs compared every falling edge against a tenure-level model.
// Backpressure: stimulus only; done and req are driven freely by the bench.
module tb_bus_arb8;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bus_arb8_if bus_if ();

    bus_arb8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks who owns the bus and how many cycles it has held it so far.
    logic       m_busy;
    logic [2:0] m_sel;
    int         m_ptr;
    int         m_held;
    logic [7:0] m_gnt;

    function automatic int find_next(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    // Model update: first requester found from the pointer, tenure capped at MAX_HOLD cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_sel  <= 3'd0;
            m_ptr  <= 0;
            m_held <= 0;
        end else if (!m_busy) begin
            if (bus_if.req != 8'h00) begin
                m_busy <= 1'b1;
                m_sel  <= 3'(find_next(bus_if.req, m_ptr));
                m_held <= 1;
            end
        end else if (bus_if.done || !bus_if.req[m_sel] ||
                     (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
            m_ptr <= (int'(m_sel) + 1) % 8;
            if (bus_if.req != 8'h00) begin
                m_sel  <= 3'(find_next(bus_if.req, (int'(m_sel) + 1) % 8));
                m_held <= 1;
            end else begin
                m_busy <= 1'b0;
            end
        end else begin
            m_held <= m_held + 1;
        end
    end

    always_comb m_gnt = m_busy ? (8'b1 << m_sel) : 8'h00;

    // Compare process: outputs are meaningful every cycle, including during reset.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_gnt", bus_if.gnt, m_gnt);
            chk("model_sel", {5'b0, bus_if.sel}, {5'b0, m_sel});
            chk("model_busy", {7'b0, bus_if.busy}, {7'b0, m_busy});
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] rot_exp [8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rot_exp  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

        // Reset with all sources requesting.
        rst = 1'b1;
        bus_if.req  = 8'hFF;
        bus_if.done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", bus_if.gnt, 8'h00);
        chk("rst_sel", {5'b0, bus_if.sel}, 8'h00);
        chk("rst_busy", {7'b0, bus_if.busy}, 8'h00);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("first_gnt", bus_if.gnt, 8'h01);
        chk("first_sel", {5'b0, bus_if.sel}, 8'h00);
        chk("first_busy", {7'b0, bus_if.busy}, 8'h01);

        // Rotation: done every cycle hands over to the next index.
        #2 bus_if.done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rot_gnt", bus_if.gnt, rot_exp[i]);
            chk("rot_sel", {5'b0, bus_if.sel}, 8'((i + 1) % 8));
            chk("rot_busy", {7'b0, bus_if.busy}, 8'h01);
        end

        // Asynchronous reset mid-tenure, then skipping over idle sources.
        #2;
        rst = 1'b1;
        bus_if.done = 1'b0;
        bus_if.req  = 8'h90;
        #1;
        chk("rst_async_gnt", bus_if.gnt, 8'h00);
        chk("rst_async_busy", {7'b0, bus_if.busy}, 8'h00);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("skip_gnt0", bus_if.gnt, 8'h10);
        chk("skip_sel0", {5'b0, bus_if.sel}, 8'h04);
        #2 bus_if.done = 1'b1;
        @(negedge clk);
        chk("skip_gnt1", bus_if.gnt, 8'h80);
        chk("skip_sel1", {5'b0, bus_if.sel}, 8'h07);
        @(negedge clk);
        chk("skip_gnt2", bus_if.gnt, 8'h10);
        chk("skip_sel2", {5'b0, bus_if.sel}, 8'h04);

        // Hold limit: two persistent requesters alternate every MAX_HOLD cycles.
        #2;
        rst = 1'b1;
        bus_if.done = 1'b0;
        bus_if.req  = 8'h03;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("hold_gnt", bus_if.gnt, (((i / 4) % 2) == 1) ? 8'h02 : 8'h01);
        end

        // Sole requester is re-granted back-to-back at the hold limit.
        #2 bus_if.req = 8'h08;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("sole_gnt", bus_if.gnt, 8'h08);
            chk("sole_busy", {7'b0, bus_if.busy}, 8'h01);
        end

        // Owner withdraws: source 5 owns, then drops while source 1 waits.
        #2 bus_if.req = 8'h20;
        @(negedge clk);
        chk("wd_gnt0", bus_if.gnt, 8'h20);
        chk("wd_sel0", {5'b0, bus_if.sel}, 8'h05);
        #2 bus_if.req = 8'h22;
        @(negedge clk);
        chk("wd_gnt1", bus_if.gnt, 8'h20);
        #2 bus_if.req = 8'h02;
        @(negedge clk);
        chk("wd_gnt2", bus_if.gnt, 8'h02);
        chk("wd_sel2", {5'b0, bus_if.sel}, 8'h01);
        #2 bus_if.req = 8'h00;
        @(negedge clk);
        chk("idle_gnt", bus_if.gnt, 8'h00);
        chk("idle_busy", {7'b0, bus_if.busy}, 8'h00);
        chk("idle_sel", {5'b0, bus_if.sel}, 8'h01);

        // done while idle is ignored; one-cycle tenure with done, sole requester re-chosen.
        #2 bus_if.done = 1'b1;
        @(negedge clk);
        chk("idle_done_busy", {7'b0, bus_if.busy}, 8'h00);
        #2 bus_if.req = 8'h01;
        @(negedge clk);
        chk("idle_done_gnt", bus_if.gnt, 8'h01);
        @(negedge clk);
        chk("regrant_gnt", bus_if.gnt, 8'h01);
        #2;
        bus_if.req  = 8'h00;
        bus_if.done = 1'b0;
        @(negedge clk);
        chk("end_busy", {7'b0, bus_if.busy}, 8'h00);

        // Random tail, checked by the model only.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            bus_if.req  = 8'($urandom);
            bus_if.done = ($urandom_range(0, 3) == 0);
            if (i == 150) begin
                rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
